// File: rtl/seven_seg_msg_ctrl.sv
// Seven-segment controller: hex value with optional leading-zero blanking, overridden by
// timed 4-letter status banners with a one-deep pending slot and optional blinking.
module seven_seg_msg_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int VAL_W        = 16,
    parameter int NUM_MSG      = 4,
    parameter int HOLD_CYCLES  = 8000000,
    parameter int BLINK_CYCLES = 4000000,
    localparam int MSG_W       = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [VAL_W-1:0]        iValue,
    input  logic                    iLZB,
    input  logic                    iMsg_req,
    input  logic [MSG_W-1:0]        iMsg_id,
    input  logic                    iBlink_en,
    output logic                    oMsg_busy,
    output logic [NUM_DIGITS*7-1:0] o_seven
);
    localparam int VAL_DIGITS = VAL_W / 4;
    localparam int HOLD_W     = $clog2(HOLD_CYCLES + 1);
    localparam int BLINK_W    = $clog2(BLINK_CYCLES + 1);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef enum logic {IDLE, BANNER} state_t;

    state_t               state_q, state_d;
    logic [MSG_W-1:0]     id_q, id_d, pend_id_q, pend_id_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic                 phase_q, phase_d;
    logic [NUM_DIGITS*7-1:0] seg_d;
    logic                 busy_d;
    logic [27:0]          msg_word;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Message word packs digit 3 in the top 7 bits down to digit 0 in the bottom.
    function automatic logic [27:0] msg_rom(input logic [MSG_W-1:0] id);
        int unsigned idx;
        idx = 32'(id);
        case (idx)
            0:       msg_rom = {7'b0010010, 7'b0001000, 7'b1100011, 7'b0000110};
            1:       msg_rom = {7'b0001100, 7'b1000111, 7'b0001000, 7'b0010001};
            2:       msg_rom = {7'b1111001, 7'b0100001, 7'b1000111, 7'b0000110};
            3:       msg_rom = {7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
            default: msg_rom = {DASH, DASH, DASH, DASH};
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        pend_id_d    = pend_id_q;
        pend_valid_d = pend_valid_q;
        hold_d       = hold_q;
        blink_d      = blink_q;
        phase_d      = phase_q;
        case (state_q)
            IDLE: begin
                if (iMsg_req) begin
                    state_d = BANNER;
                    id_d    = iMsg_id;
                    hold_d  = '0;
                    blink_d = '0;
                    phase_d = 1'b0;
                end
            end
            BANNER: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    // A request arriving on the expiry cycle is newer than the slot, so it wins.
                    if (iMsg_req || pend_valid_q) begin
                        id_d         = iMsg_req ? iMsg_id : pend_id_q;
                        hold_d       = '0;
                        blink_d      = '0;
                        phase_d      = 1'b0;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                    if (blink_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                        blink_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                    if (iMsg_req) begin
                        pend_valid_d = 1'b1;
                        pend_id_d    = iMsg_id;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output is built from next-state so the register shows the new state one cycle after the inputs.
    assign msg_word = msg_rom(id_d);
    assign busy_d   = (state_d == BANNER) || pend_valid_d;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [6:0] idle_glyph;
            logic [6:0] ban_glyph;
            if (gi < VAL_DIGITS) begin : g_val
                logic lead_zero;
                if (gi == 0) begin : g_lsd
                    assign lead_zero = 1'b0;
                end else begin : g_upper
                    assign lead_zero = (iValue[VAL_W-1:4*gi] == '0);
                end
                assign idle_glyph = (iLZB && lead_zero) ? BLANK : hex_glyph(iValue[4*gi +: 4]);
            end else begin : g_noval
                assign idle_glyph = BLANK;
            end
            if (gi < 4) begin : g_msg
                assign ban_glyph = msg_word[7*gi +: 7];
            end else begin : g_dash
                assign ban_glyph = DASH;
            end
            assign seg_d[7*gi +: 7] = (state_d == BANNER)
                                    ? ((iBlink_en && phase_d) ? BLANK : ban_glyph)
                                    : idle_glyph;
        end
    endgenerate

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= IDLE;
            id_q         <= '0;
            pend_id_q    <= '0;
            pend_valid_q <= 1'b0;
            hold_q       <= '0;
            blink_q      <= '0;
            phase_q      <= 1'b0;
            o_seven      <= '1;
            oMsg_busy    <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            pend_id_q    <= pend_id_d;
            pend_valid_q <= pend_valid_d;
            hold_q       <= hold_d;
            blink_q      <= blink_d;
            phase_q      <= phase_d;
            o_seven      <= seg_d;
            oMsg_busy    <= busy_d;
        end
    end
endmodule

// File: tb/tb_seven_seg_msg_ctrl.sv
// Scoreboard bench for seven_seg_msg_ctrl: a string-based banner/value model queues the
// expected display for every cycle; a monitor pops and compares one cycle later.
module tb_seven_seg_msg_ctrl;
    localparam int ND    = 8;
    localparam int HOLD  = 10;
    localparam int BLINK = 3;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [15:0] iValue = '0;
    logic        iLZB = 1'b0;
    logic        iMsg_req = 1'b0;
    logic [2:0]  iMsg_id = '0;
    logic        iBlink_en = 1'b0;
    logic        oMsg_busy;
    logic [55:0] o_seven;

    seven_seg_msg_ctrl #(
        .NUM_DIGITS(ND), .VAL_W(16), .NUM_MSG(8),
        .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iValue(iValue), .iLZB(iLZB),
        .iMsg_req(iMsg_req), .iMsg_id(iMsg_id), .iBlink_en(iBlink_en),
        .oMsg_busy(oMsg_busy), .o_seven(o_seven)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [55:0] seg;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] tv_value = '0;
    bit tv_lzb = 0;
    bit tv_blink = 0;

    // Model: is a banner on screen, how many of its cycles have elapsed, which text, pending slot.
    bit m_ban = 0;
    bit m_pv = 0;
    int m_el = 0;
    int m_id = 0;
    int m_pid = 0;

    function automatic string msg_text(input int id);
        case (id)
            0: return "SAuE";
            1: return "PLAY";
            2: return "IdLE";
            3: return "donE";
            default: return "----";
        endcase
    endfunction

    function automatic logic [6:0] char_glyph(input byte c);
        case (c)
            "S": return 7'b0010010;
            "A": return 7'b0001000;
            "u": return 7'b1100011;
            "E": return 7'b0000110;
            "P": return 7'b0001100;
            "L": return 7'b1000111;
            "Y": return 7'b0010001;
            "I": return 7'b1111001;
            "d": return 7'b0100001;
            "o": return 7'b0100011;
            "n": return 7'b0101011;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        string s;
        int msd;
        e.busy = m_ban || m_pv;
        e.seg  = '1;
        if (m_ban) begin
            if (!(tv_blink && ((m_el / BLINK) % 2 == 1))) begin
                s = msg_text(m_id);
                for (int d = 0; d < ND; d++)
                    e.seg[7*d +: 7] = (d < 4) ? char_glyph(s[3-d]) : 7'b0111111;
            end
        end else begin
            msd = 0;
            for (int d = 0; d < 4; d++)
                if (tv_value[4*d +: 4] != 4'h0) msd = d;
            for (int d = 0; d < 4; d++)
                if (!tv_lzb || d <= msd) e.seg[7*d +: 7] = hex_glyph(tv_value[4*d +: 4]);
        end
        return e;
    endfunction

    task automatic model_step(input bit rst, input bit req, input int id);
        if (rst) begin
            m_ban = 0;
            m_pv  = 0;
        end else if (!m_ban) begin
            if (req) begin
                m_ban = 1;
                m_el  = 0;
                m_id  = id;
            end
        end else if (m_el == HOLD - 1) begin
            if (req || m_pv) begin
                m_id = req ? id : m_pid;
                m_el = 0;
                m_pv = 0;
            end else begin
                m_ban = 0;
            end
        end else begin
            m_el++;
            if (req) begin
                m_pv  = 1;
                m_pid = id;
            end
        end
    endtask

    task automatic push_expected(input bit rst);
        exp_t e;
        if (rst) begin
            e.seg  = '1;
            e.busy = 1'b0;
        end else begin
            e = expect_now();
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit req = 0, input int id = 0, input bit rst = 0);
        @(negedge iCLK);
        iRST      = rst;
        iMsg_req  = req;
        iMsg_id   = id[2:0];
        iValue    = tv_value;
        iLZB      = tv_lzb;
        iBlink_en = tv_blink;
        if (req && !rst)
            $display("cyc %0d: request id=%0d value=%h lzb=%0b blink=%0b", cyc, id, tv_value, tv_lzb, tv_blink);
        model_step(rst, req, id);
        push_expected(rst);
        cyc++;
    endtask

    // Reset asserted between clock edges must blank the display without waiting for a clock.
    task automatic async_reset();
        @(negedge iCLK);
        #2;
        iRST     = 1'b1;
        iMsg_req = 1'b0;
        #1;
        vectors++;
        if (o_seven !== '1 || oMsg_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got seg=%h busy=%b, want seg=%h busy=0", o_seven, oMsg_busy, {56{1'b1}});
        end
        $display("cyc %0d: asynchronous reset", cyc);
        model_step(1, 0, 0);
        push_expected(1);
        tick(0, 0, 1);
    endtask

    always @(posedge iCLK) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (o_seven !== e.seg || oMsg_busy !== e.busy) begin
                miscompares++;
                $display("FAIL display t=%0t: got seg=%h busy=%b, want seg=%h busy=%b",
                         $time, o_seven, oMsg_busy, e.seg, e.busy);
            end
        end
    end

    initial begin
        int req;
        int id;
        tick(0, 0, 1);
        tick(0, 0, 1);

        // Value display and leading-zero blanking.
        tv_value = 16'h00A3; tv_lzb = 1; tick(); tick();
        tv_lzb = 0; tick(); tick();
        tv_value = 16'h0000; tv_lzb = 1; tick(); tick();
        tv_value = 16'h0100; tick(); tick();

        // Single banner with exact hold length.
        tv_value = 16'h1234; tv_lzb = 0;
        tick(1, 1); repeat (12) tick();

        // Back-to-back requests, latest pending wins.
        tick(1, 0); tick(); tick(); tick(1, 2); tick(); tick(1, 3); repeat (25) tick();

        // Request exactly on the expiry cycle.
        tick(1, 1); repeat (9) tick(); tick(1, 2); repeat (12) tick();

        // Blinking banner.
        tv_blink = 1; tick(1, 2); repeat (12) tick(); tv_blink = 0;

        // Reset mid-banner with a pending request, then an out-of-range ID.
        tick(1, 1); tick(); tick(); tick(1, 3); async_reset();
        repeat (15) tick();
        tick(1, 5); repeat (12) tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) tv_value = 16'($urandom >> $urandom_range(16, 31));
            if ($urandom_range(0, 9) == 0) tv_lzb = 1'($urandom);
            if ($urandom_range(0, 15) == 0) tv_blink = 1'($urandom);
            req = ($urandom_range(0, 7) == 0) ? 1 : 0;
            id  = $urandom_range(0, 7);
            if ($urandom_range(0, 199) == 0) async_reset();
            else tick(req[0], id);
        end
        repeat (3) tick();

        repeat (3) @(negedge iCLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seven_seg_msg_ctrl.md
Name: seven_seg_msg_ctrl

Overview:
Parametrised seven-segment display controller for the DE2-class board displays. It shows a hex value on the low digits, with optional leading-zero blanking. A pulse request overrides the display with a timed 4-letter status banner (SAuE / PLAY / IdLE / donE) for a fixed number of cycles, with optional blinking. The banner path has a one-deep pending slot, so back-to-back requests are not lost. It sits between the top-level control FSM and the HEX pins and replaces per-design hard-coded decoders.

Parameters:
NUM_DIGITS, 8, number of physical digits (must be at least 4).
VAL_W, 16, width of the displayed value; VAL_DIGITS = VAL_W/4, and VAL_W must be a multiple of 4 with VAL_DIGITS ≤ NUM_DIGITS.
NUM_MSG, 4, number of message IDs; MSG_W = max(1, clog2(NUM_MSG)).
HOLD_CYCLES, 8000000, number of cycles a banner stays on screen (≥ 2).
BLINK_CYCLES, 4000000, half-period of banner blink (≥ 1).

Ports:
iCLK  in  1  system clock
iRST  in  1  reset; asynchronous, active-high
iValue  in  VAL_W  value shown in IDLE, nibble 0 on digit 0
iLZB  in  1  1 = blank leading zero nibbles
iMsg_req  in  1  single-cycle banner request
iMsg_id  in  MSG_W  banner ID, sampled with iMsg_req
iBlink_en  in  1  1 = banner blinks
oMsg_busy  out  1  1 while a banner is shown or pending
o_seven  out  NUM_DIGITS*7  active-low segments, digit d at [7d+6:7d], bit i = segment i (0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle)

Behaviour:
- Reset (async, iRST=1):
  - o_seven = all ones (blank).
  - oMsg_busy = 0.
  - State IDLE, hold and blink counters = 0, pending slot empty.
- All outputs are registered. o_seven reflects inputs and state with 1-cycle latency.
- Hex glyphs: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- Other glyphs: blank 1111111, dash 0111111.
- Letters: S=5, A, u 1100011, E, P 0001100, L 1000111, Y 0010001, I=1, d, o 0100011, n 0101011.
- Message ROM (digit 3..0): ID0 "SAuE", ID1 "PLAY", ID2 "IdLE", ID3 "donE". IDs 4..NUM_MSG-1 show "----".
- IDLE display:
  - Digits 0..VAL_DIGITS-1 show hex nibbles of iValue.
  - Digits ≥ VAL_DIGITS are blank.
  - With iLZB=1, every nibble above the most significant nonzero nibble is blank. Digit 0 is always shown, so value 0 shows "0".
- BANNER display: digits 3..0 show the message; digits ≥ 4 show dash.
- States: IDLE, BANNER.
  - IDLE, iMsg_req=1: capture ID, clear hold and blink counters, go to BANNER. The banner appears on o_seven the next cycle.
  - BANNER: the hold counter increments every cycle. The banner is shown for exactly HOLD_CYCLES consecutive output cycles.
  - At expiry with pending slot full: load pending ID, clear counters, empty slot, stay in BANNER. The new banner starts immediately, with no IDLE cycle.
  - At expiry with slot empty: go to IDLE; the value is shown the next cycle.
  - BANNER, iMsg_req=1 before expiry: write ID into pending slot. Latest request wins; an earlier pending ID is overwritten.
  - iMsg_req on the expiry cycle: the request is treated as pending and loaded directly at that expiry.
- Blink (BANNER only): the blink counter runs 0..BLINK_CYCLES-1 and toggles a phase bit on wrap.
  - Phase 0 = visible, phase 1 = all digits blank.
  - Phase is reset to visible at every banner start.
  - iBlink_en=0 forces visible. Blink does not alter hold timing.
- oMsg_busy = 1 in BANNER or when the pending slot is full. It deasserts together with the return to the IDLE display.
- iRST asserted mid-banner: immediate blank, pending request discarded.
- iValue and iLZB changes in IDLE appear 1 cycle later. Changes during BANNER are not visible until the return to IDLE.

Test Plan:
(Tests use HOLD_CYCLES=10, BLINK_CYCLES=3, NUM_DIGITS=8, VAL_W=16.)
1. Reset then iValue=16'h00A3, iLZB=1 → digits 3..0 = blank, blank, A, 3; digits 7..4 blank. With iLZB=0 → digits 3..0 = 0, 0, A, 3. iValue=0 with iLZB=1 → digit 0 = "0", all other digits blank.
2. Pulse iMsg_req with ID1 at cycle t → from cycle t+1, digits 3..0 = "PLAY" and 7..4 = dash for exactly 10 cycles, oMsg_busy=1 throughout. Value returns at cycle t+11 with oMsg_busy=0.
3. ID0 at t, then ID2 at t+3 and ID3 at t+5 → "SAuE" for 10 cycles, then "donE" immediately for 10 cycles (ID2 dropped), then IDLE. oMsg_busy stays 1 continuously for 20 cycles.
4. Request on the exact expiry cycle → the new banner starts with no IDLE or value cycle in between.
5. iBlink_en=1, ID2 → display pattern visible 3, blank 3, visible 3, blank 1 cycles, then IDLE; total banner time is still 10 cycles.
6. iRST pulsed at banner cycle 4 with a pending ID → o_seven all ones asynchronously, oMsg_busy=0. After release the value is shown and the pending banner never appears. An ID above 3 with NUM_MSG=8 shows "----".
